apb_stdout_stream: RTL

Synthesizable, parametrised successor to the simulation-only APB stdout sink. Cores write characters through the peripheral APB bus. Each character is tagged with its cluster and core index, queued in a shared FIFO, and drained on a byte stream port towards a UART or host bridge. The block adds a configurable full-FIFO policy (stall or drop), error responses, and a readable status register.

---
 rtl/apb_stdout_stream_pkg.sv | 20 ++
 rtl/apb_stdout_stream_if.sv | 26 ++
 rtl/apb_stdout_stream_fifo.sv | 55 +++++
 rtl/apb_stdout_stream.sv | 102 ++++++++++
 4 files changed

// File: rtl/apb_stdout_stream_pkg.sv
// Shared types and address-map constants for the APB stdout stream peripheral.
// Entries carry the source cluster/core alongside the character byte.
package apb_stdout_pkg;

  typedef struct packed {
    logic [3:0] cl;
    logic [3:0] core;
    logic [7:0] ch;
  } entry_t;

  localparam int unsigned STATUS_SEL_BIT = 11;
  localparam int unsigned CL_LSB         = 7;
  localparam int unsigned CORE_LSB       = 3;
  localparam logic [7:0]  CHAR_EOL       = 8'h0A;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/apb_stdout_stream_if.sv
// APB3 bus bundle shared by the stdout stream peripheral and its masters.
// Slave sees the request fields as inputs and drives the response fields.
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_stdout_stream_fifo.sv
// Generic synchronous FIFO; head is read straight from storage so a push is visible next cycle.
// Pushes while full and pops while empty are ignored; flush_i empties it in one cycle.
module fifo_v3 #(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH:0]   usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH:0]   CNT_ONE  = (ADDR_DEPTH+1)'(1);
  localparam logic [ADDR_DEPTH:0]   CNT_FULL = (ADDR_DEPTH+1)'(DEPTH);
  localparam logic [ADDR_DEPTH-1:0] PTR_ONE  = ADDR_DEPTH'(1);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  clr, do_push, do_pop;

  assign clr     = ~rst_ni | flush_i;
  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign do_push = push_i & ~full_o & ~clr;
  assign do_pop  = pop_i & ~empty_o & ~clr;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_ONE;
      else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Storage needs no reset: the head is only observed while the count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/apb_stdout_stream.sv
// APB character sink: tagged bytes go through a shared FIFO to a valid/ready stream, head visible 1 cycle after push.
// Full FIFO either stalls pready (BLOCKING=1) or drops and counts; pready depends only on the registered full flag.
module apb_stdout_stream
  import apb_stdout_pkg::*;
#(
  parameter int unsigned N_CORES    = 8,
  parameter int unsigned N_CLUSTERS = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter bit          BLOCKING   = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  APB_BUS.Slave        apb,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [7:0]   out_char_o,
  output logic [3:0]   out_cluster_o,
  output logic [3:0]   out_core_o,
  output logic         out_eol_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  entry_t             push_entry, head;
  logic [LVL_W-1:0]   usage;
  logic [15:0]        level;
  logic [15:0]        drop_cnt_q;
  logic               fifo_full, fifo_empty;
  logic [3:0]         addr_cl, addr_core;
  logic               is_status, in_range, access, char_wr;
  logic               stall, push, pop, drop, clr_drop;

  // Address decode
  assign addr_cl   = apb.paddr[CL_LSB +: 4];
  assign addr_core = apb.paddr[CORE_LSB +: 4];
  assign is_status = apb.paddr[STATUS_SEL_BIT];
  assign in_range  = (32'(addr_cl) < N_CLUSTERS) && (32'(addr_core) < N_CORES);

  assign access  = apb.psel & apb.penable;
  assign char_wr = access & apb.pwrite & ~is_status;

  // Full is a registered flag, so a same-cycle pop never releases a stalled write.
  assign stall    = BLOCKING & char_wr & in_range & fifo_full;
  assign push     = ~rst_i & char_wr & in_range & ~fifo_full;
  assign drop     = ~rst_i & ~BLOCKING & char_wr & in_range & fifo_full;
  assign clr_drop = ~rst_i & access & apb.pwrite & is_status & apb.pwdata[0];

  assign apb.pready  = rst_i | ~stall;
  assign apb.pslverr = ~rst_i & char_wr & ~in_range;

  always_comb begin
    apb.prdata = '0;
    if (!rst_i && !apb.pwrite && is_status) begin
      apb.prdata[31:0] = {drop_cnt_q, level};
    end
  end

  // A status-write clear takes priority over a drop in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_drop) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      drop_cnt_q <= sat_inc16(drop_cnt_q);
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.cl   = addr_cl;
    push_entry.core = addr_core;
    push_entry.ch   = apb.pwdata[7:0];
  end

  fifo_v3 #(
    .DATA_WIDTH ($bits(entry_t)),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (rst_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (usage),
    .data_i  (push_entry),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

  assign level = 16'(usage);

  // Outputs read as zero whenever nothing is queued, which covers the reset state.
  assign out_valid_o   = ~fifo_empty;
  assign pop           = out_valid_o & out_ready_i;
  assign out_char_o    = fifo_empty ? 8'h00 : head.ch;
  assign out_cluster_o = fifo_empty ? 4'h0 : head.cl;
  assign out_core_o    = fifo_empty ? 4'h0 : head.core;
  assign out_eol_o     = ~fifo_empty & (head.ch == CHAR_EOL);

endmodule
